// File: rtl/divider_array_issue_ctrl.sv
// divider_array_issue_ctrl
//
// Sequential front/back end for a combinational 16/8 array divider. The
// divider can be the exact variant or the approximate-cell variant.
//
// Operation:
//   - An operand is taken over a valid/ready handshake. It is then held
//     stable on div_n/div_d while the array settles.
//   - After SETTLE_CYCLES cycles the array outputs are registered.
//   - Divide-by-zero and quotient overflow are detected on input and
//     finish at once with fixed result codes.
//   - The result is presented on a valid/ready output handshake.
//
// Parameters:
//   SETTLE_CYCLES  cycles div_n/div_d are held before sampling (>= 1)
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand valid
//   in_ready   out  1   operand accept
//   in_n       in   16  dividend
//   in_d       in   8   divisor
//   div_n      out  16  held dividend to the array divider
//   div_d      out  8   held divisor to the array divider
//   div_q      in   8   array quotient
//   div_r      in   8   array remainder
//   out_valid  out  1   result valid
//   out_ready  in   1   result accept
//   out_q      out  8   quotient
//   out_r      out  8   remainder
//   out_dbz    out  1   divisor was zero
//   out_ovf    out  1   quotient does not fit in 8 bits

module divider_array_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_n,
  input  logic [7:0]  in_d,
  output logic [15:0] div_n,
  output logic [7:0]  div_d,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_q,
  output logic [7:0]  out_r,
  output logic        out_dbz,
  output logic        out_ovf
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_div_n;
  logic [7:0]    r_div_d;
  logic [7:0]    r_out_q;
  logic [7:0]    r_out_r;
  logic          r_dbz;
  logic          r_ovf;

  logic          w_accept;
  logic          w_dbz;
  logic          w_ovf;
  logic          w_settle_done;

  // DONE may accept a new operand in the same edge that retires its result.
  // This keeps the pipeline full when out_ready is held high.
  assign in_ready      = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept      = in_valid && in_ready;

  // Overflow: the high dividend byte is already >= divisor, so q > 8'hFF.
  assign w_dbz         = (in_d == 8'd0);
  assign w_ovf         = !w_dbz && (in_n[15:8] >= in_d);
  assign w_settle_done = (r_state == S_SETTLE) && (r_cnt == LAST_CNT);

  // out_valid is taken straight from the state register so it cannot glitch.
  assign out_valid = (r_state == S_DONE);
  assign div_n     = r_div_n;
  assign div_d     = r_div_d;
  assign out_q     = r_out_q;
  assign out_r     = r_out_r;
  assign out_dbz   = r_dbz;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_dbz || w_ovf) begin
            w_next = S_DONE;
          end else begin
            w_next = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (w_settle_done) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          if (w_dbz || w_ovf) begin
            w_next = S_DONE;
          end else begin
            w_next = S_SETTLE;
          end
        end else if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. Special results are produced directly at acceptance.
  // A normal result samples the array only on the SETTLE exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_div_n <= '0;
      r_div_d <= '0;
      r_out_q <= '0;
      r_out_r <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_div_n <= in_n;
        r_div_d <= in_d;
        if (w_dbz) begin
          r_out_q <= 8'hFF;
          r_out_r <= in_n[7:0];
          r_dbz   <= 1'b1;
          r_ovf   <= 1'b0;
        end else if (w_ovf) begin
          r_out_q <= 8'hFF;
          r_out_r <= 8'hFF;
          r_dbz   <= 1'b0;
          r_ovf   <= 1'b1;
        end
      end else if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_settle_done) begin
          r_out_q <= div_q;
          r_out_r <= div_r;
          r_dbz   <= 1'b0;
          r_ovf   <= 1'b0;
        end
      end
    end
  end

endmodule
